// File: rtl/turf_cin_align.sv
// rtl/turf_cin_align.sv - TURF CIN receive training, bitslip control and 32-bit word framing
module turf_cin_align #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int          LOCK_COUNT    = 16,
  parameter int          SEARCH_CYCLES = 16,
  parameter int          BITSLIP_WAIT  = 4
) (
  input  logic        rxclk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  cin_i,
  input  logic        align_en_i,
  output logic        bitslip_o,
  output logic [31:0] cin_word_o,
  output logic        cin_valid_o,
  output logic        locked_o,
  output logic        align_err_o,
  output logic [1:0]  slip_count_o
);

  localparam int TW = $clog2(SEARCH_CYCLES + BITSLIP_WAIT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_SLIP, S_SLIP_WAIT, S_VERIFY, S_LOCKED
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   sr;
  logic [2:0]    ph;
  logic [TW-1:0] timer;
  logic [7:0]    match_cnt;
  logic [2:0]    slip_cnt;
  logic          match, boundary, search_to, wait_done, lock_hit;

  assign match     = (sr == TRAIN_PATTERN);
  assign boundary  = (ph == 3'd0);
  assign search_to = (timer == TW'(SEARCH_CYCLES - 1));
  assign wait_done = (timer == TW'(BITSLIP_WAIT - 1));
  assign lock_hit  = (match_cnt >= 8'(LOCK_COUNT - 1));

  always_ff @(posedge rxclk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!align_en_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      state_nxt = S_SEARCH;
        S_SEARCH:    if (match) state_nxt = S_VERIFY;
                     else if (search_to) state_nxt = S_SLIP;
        S_SLIP:      state_nxt = S_SLIP_WAIT;
        S_SLIP_WAIT: if (wait_done) state_nxt = S_SEARCH;
        S_VERIFY:    if (boundary) begin
                       if (!match) state_nxt = S_SEARCH;
                       else if (lock_hit) state_nxt = S_LOCKED;
                     end
        S_LOCKED:    state_nxt = S_LOCKED;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bitslip_o = 1'b0;
    locked_o  = 1'b0;
    if (state == S_SLIP)   bitslip_o = 1'b1;
    if (state == S_LOCKED) locked_o  = 1'b1;
  end

  // The phase counter is re-anchored on the first match so ph==0 marks a full word in sr.
  always_ff @(posedge rxclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr           <= '0;
      ph           <= '0;
      timer        <= '0;
      match_cnt    <= '0;
      slip_cnt     <= '0;
      slip_count_o <= '0;
      align_err_o  <= 1'b0;
      cin_word_o   <= '0;
      cin_valid_o  <= 1'b0;
    end else begin
      sr          <= {cin_i, sr[31:4]};
      cin_valid_o <= 1'b0;
      if (!align_en_i) begin
        ph           <= '0;
        timer        <= '0;
        match_cnt    <= '0;
        slip_cnt     <= '0;
        slip_count_o <= '0;
        align_err_o  <= 1'b0;
      end else begin
        ph    <= ph + 3'd1;
        timer <= timer + TW'(1);
        case (state)
          S_IDLE: timer <= '0;
          S_SEARCH: begin
            if (match) begin
              ph        <= 3'd1;
              match_cnt <= 8'd1;
              slip_cnt  <= '0;
            end
          end
          S_SLIP: begin
            timer        <= '0;
            slip_count_o <= slip_count_o + 2'd1;
            if (slip_cnt == 3'd3) begin
              slip_cnt    <= '0;
              align_err_o <= 1'b1;
            end else begin
              slip_cnt <= slip_cnt + 3'd1;
            end
          end
          S_SLIP_WAIT: if (wait_done) timer <= '0;
          S_VERIFY: begin
            if (boundary) begin
              if (match) begin
                match_cnt <= match_cnt + 8'd1;
              end else begin
                match_cnt <= '0;
                timer     <= '0;
              end
            end
          end
          S_LOCKED: begin
            if (boundary) begin
              cin_word_o  <= sr;
              cin_valid_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turf_cin_align.sv
// tb/tb_turf_cin_align.sv - randomized bench for turf_cin_align with a bitslip-capable deserializer model
module tb_turf_cin_align;

  localparam logic [31:0] PAT = 32'hA55A6996;

  logic        rxclk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [3:0]  cin_i = 4'h0;
  logic        align_en_i = 1'b0;
  logic        bitslip_o;
  logic [31:0] cin_word_o;
  logic        cin_valid_o;
  logic        locked_o;
  logic        align_err_o;
  logic [1:0]  slip_count_o;

  always #5 rxclk_i = ~rxclk_i;

  turf_cin_align dut (
    .rxclk_i      (rxclk_i),
    .rst_n_i      (rst_n_i),
    .cin_i        (cin_i),
    .align_en_i   (align_en_i),
    .bitslip_o    (bitslip_o),
    .cin_word_o   (cin_word_o),
    .cin_valid_o  (cin_valid_o),
    .locked_o     (locked_o),
    .align_err_o  (align_err_o),
    .slip_count_o (slip_count_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Serial source: words are sent LSB first; the deserializer pointer p skips one bit per bitslip.
  logic [31:0] words[$];
  int p;

  function automatic logic get_bit(input int idx);
    logic [31:0] w;
    if (idx < 0) return 1'b0;
    if (idx / 32 >= words.size()) return 1'b0;
    w = words[idx / 32];
    return w[idx % 32];
  endfunction

  function automatic logic [3:0] nib(input int idx);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = get_bit(idx + i);
    return r;
  endfunction

  // Reference model: word window from the last 8 nibbles, phase from the cycle of the anchoring match.
  int          m_mode;   // 0 idle, 1 search, 2 slip, 3 slip wait, 4 verify, 5 locked
  logic [3:0]  m_hist[$];
  int          m_cyc, m_anchor, m_t, m_cnt, m_sc, m_slips;
  logic        m_err, m_valid;
  logic [31:0] m_word, m_sr;
  bit          m_match, m_bnd;

  always @(posedge rxclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_mode = 0; m_cyc = 0; m_anchor = 0; m_t = 0; m_cnt = 0; m_sc = 0; m_slips = 0;
      m_err = 1'b0; m_valid = 1'b0; m_word = '0;
      m_hist.delete();
      repeat (8) m_hist.push_back(4'h0);
    end else begin
      m_sr = '0;
      for (int i = 0; i < 8; i++) m_sr[4*i +: 4] = m_hist[i];
      m_match = (m_sr == PAT);
      m_bnd = ((m_cyc - m_anchor) % 8) == 0;
      m_valid = 1'b0;
      m_hist.push_back(cin_i);
      void'(m_hist.pop_front());
      if (!align_en_i) begin
        m_mode = 0; m_t = 0; m_cnt = 0; m_sc = 0; m_slips = 0; m_err = 1'b0;
      end else begin
        case (m_mode)
          0: begin m_mode = 1; m_t = 0; end
          1: begin
            if (m_match) begin
              m_mode = 4; m_cnt = 1; m_sc = 0; m_anchor = m_cyc;
            end else if (m_t == 15) m_mode = 2;
            else m_t++;
          end
          2: begin
            m_slips++; m_sc++;
            if (m_sc == 4) begin m_err = 1'b1; m_sc = 0; end
            m_mode = 3; m_t = 0;
          end
          3: begin
            if (m_t == 3) begin m_mode = 1; m_t = 0; end
            else m_t++;
          end
          4: begin
            if (m_bnd) begin
              if (m_match) begin
                m_cnt++;
                if (m_cnt == 16) m_mode = 5;
              end else begin
                m_mode = 1; m_cnt = 0; m_t = 0;
              end
            end
          end
          default: begin
            if (m_bnd) begin m_word = m_sr; m_valid = 1'b1; end
          end
        endcase
      end
      m_cyc++;
    end
  end

  int          n, lock_n, err_n, cnt, bad;
  int          slip_n[$];
  int          vedges[$];
  logic [31:0] vwords[$];
  logic [31:0] data[$];
  logic [31:0] nonpat[$];

  task automatic step();
    @(posedge rxclk_i);
    n++;
    @(negedge rxclk_i);
    check("cycle", {bitslip_o, locked_o, cin_valid_o, align_err_o, slip_count_o, cin_word_o},
          {(m_mode == 2), (m_mode == 5), m_valid, m_err, 2'(m_slips % 4), m_word});
    if (bitslip_o) begin slip_n.push_back(n); p++; end
    if (locked_o && lock_n < 0) lock_n = n;
    if (align_err_o && err_n < 0) err_n = n;
    if (cin_valid_o) begin vwords.push_back(cin_word_o); vedges.push_back(n); end
    cin_i = nib(p);
    p += 4;
  endtask

  task automatic start(input int offset_bits);
    p = offset_bits; n = 0; lock_n = -1; err_n = -1;
    slip_n.delete(); vwords.delete(); vedges.delete();
    align_en_i = 1'b1;
    cin_i = nib(p);
    p += 4;
  endtask

  task automatic go_idle();
    align_en_i = 1'b0;
    words.delete();
    p = 0;
    repeat (4) step();
  endtask

  task automatic gap_check(input string tag);
    bad = 0;
    for (int i = 1; i < vedges.size(); i++) if (vedges[i] - vedges[i-1] != 8) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge rxclk_i);
    check("rst_outputs", {bitslip_o, locked_o, cin_valid_o, align_err_o, slip_count_o, cin_word_o}, 0);
    rst_n_i = 1'b1;
    go_idle();

    // Aligned training then constant data
    repeat (30) words.push_back(PAT);
    repeat (20) words.push_back(32'h12345678);
    start(0);
    repeat (400) step();
    check("s1_slips", slip_n.size(), 0);
    check("s1_lock_lat", lock_n, 129);
    cnt = 0;
    foreach (vwords[i]) if (vwords[i] == 32'h12345678) cnt++;
    check("s1_data_valids", cnt, 19);
    gap_check("s1_valid_gap");
    check("s1_slip_count", slip_count_o, 0);
    go_idle();

    // Three-nibble delay, random data must arrive unrotated
    data.delete();
    repeat (10) begin
      logic [31:0] d;
      d = $urandom();
      if (d == PAT) d = ~d;
      data.push_back(d);
    end
    repeat (30) words.push_back(PAT);
    foreach (data[i]) words.push_back(data[i]);
    start(-12);
    repeat (400) step();
    check("s2_slips", slip_n.size(), 0);
    check("s2_lock_lat", lock_n, 132);
    nonpat.delete();
    foreach (vwords[i]) if (vwords[i] != PAT) nonpat.push_back(vwords[i]);
    check("s2_ndata", nonpat.size() >= 10, 1);
    for (int i = 0; i < 10 && i < nonpat.size(); i++) check("s2_word", nonpat[i], data[i]);
    go_idle();

    // Two-bit offset needs exactly two bitslips
    repeat (60) words.push_back(PAT);
    start(2);
    repeat (350) step();
    check("s3_slips", slip_n.size(), 2);
    if (slip_n.size() >= 2) begin
      check("s3_first_slip", slip_n[0], 17);
      check("s3_slip_gap", slip_n[1] - slip_n[0], 21);
    end
    check("s3_locked", locked_o, 1);
    check("s3_slip_count", slip_count_o, 2);
    check("s3_err", align_err_o, 0);
    gap_check("s3_valid_gap");
    go_idle();

    // Dead link: periodic bitslips, sticky error after the 4th
    start(0);
    repeat (120) step();
    check("s4_nslips", slip_n.size(), 5);
    bad = 0;
    for (int i = 1; i < slip_n.size(); i++) if (slip_n[i] - slip_n[i-1] != 21) bad++;
    check("s4_slip_gap", bad, 0);
    check("s4_err_n", err_n, 81);
    check("s4_err_sticky", align_err_o, 1);
    align_en_i = 1'b0;
    step();
    check("s4_dis_err", align_err_o, 0);
    check("s4_dis_cnt", slip_count_o, 0);
    check("s4_dis_slip", bitslip_o, 0);
    go_idle();

    // Corrupted training word at verify count 5
    repeat (5) words.push_back(PAT);
    words.push_back(32'h0);
    repeat (40) words.push_back(PAT);
    start(0);
    repeat (300) step();
    check("s5_slips", slip_n.size(), 0);
    check("s5_lock_lat", lock_n, 177);
    go_idle();

    // Asynchronous reset while locked, then retrain
    repeat (30) words.push_back(PAT);
    repeat (20) words.push_back($urandom() | 32'h1);
    start(0);
    repeat (200) step();
    check("s6_locked", locked_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("s6_rst_locked", locked_o, 0);
    check("s6_rst_word", cin_word_o, 0);
    check("s6_rst_misc", {bitslip_o, cin_valid_o, align_err_o, slip_count_o}, 0);
    repeat (2) @(negedge rxclk_i);
    rst_n_i = 1'b1;
    words.delete();
    repeat (30) words.push_back(PAT);
    start(0);
    repeat (200) step();
    check("s6_relock_lat", lock_n, 129);
    go_idle();

    // Random offsets, noise prefixes, data and enable drops against the model
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 3)) words.push_back($urandom());
      repeat ($urandom_range(20, 30)) words.push_back(PAT);
      repeat (10) words.push_back($urandom());
      start($urandom_range(0, 31));
      repeat (150) step();
      if (it % 2 == 1) begin
        align_en_i = 1'b0;
        repeat (3) step();
        align_en_i = 1'b1;
      end
      repeat (200) step();
      gap_check("rnd_valid_gap");
      go_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turf_cin_align.md
Name: turf_cin_align

Overview:
- Receive-side training and word framing for the TURF CIN link.
- Consumes the 4-bit-per-rxclk nibble stream from the CIN deserializer. First-in-time bit is cin_i[0].
- Hunts for the 32-bit training pattern and drives the deserializer's bitslip until bit alignment is found. Then finds the nibble phase of the word boundary.
- After lock, delivers framed 32-bit words with a one-cycle valid strobe to the TURFIO command decoder.

Parameters:
- TRAIN_PATTERN, 32'hA55A6996, training word. It must differ from all 7 of its nibble rotations.
- LOCK_COUNT, 16, consecutive boundary-aligned pattern matches required to declare lock (1..255).
- SEARCH_CYCLES, 16, cycles spent in SEARCH without a match before a bitslip is issued (≥16).
- BITSLIP_WAIT, 4, settle cycles after each bitslip pulse (≥2).

Ports:
- rxclk_i  in  1  CIN parallel clock; the only clock.
- rst_n_i  in  1  asynchronous active-low reset.
- cin_i  in  4  deserialized nibble; bit 0 is first in time.
- align_en_i  in  1  level; high runs training and lock, low forces IDLE.
- bitslip_o  out  1  one-cycle pulse to the deserializer bitslip input.
- cin_word_o  out  32  framed word; first nibble in time is in bits [3:0].
- cin_valid_o  out  1  one-cycle strobe; cin_word_o is valid on that cycle.
- locked_o  out  1  high while in LOCKED.
- align_err_o  out  1  sticky; set when 4 bitslips pass without reaching VERIFY.
- slip_count_o  out  2  bitslips issued modulo 4, for debug.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, all counters 0, shift register sr = 0.
- sr: every cycle, sr <= {cin_i, sr[31:4]}. This happens in all states, including IDLE.
- match = (sr == TRAIN_PATTERN), evaluated on the registered sr.
- ph: 3-bit nibble phase counter.
  - On the match that causes SEARCH->VERIFY, ph <= 1.
  - Otherwise ph increments mod 8.
  - Boundary cycle = ph==0 while in VERIFY or LOCKED.
- align_en_i low in any state: IDLE next cycle.
  - Clears timers, match count, ph, slip_count_o, locked_o, align_err_o.
  - No bitslip is issued.
- IDLE: when align_en_i is high, go to SEARCH with the timer cleared.
- SEARCH: timer increments each cycle.
  - match: go to VERIFY, match count = 1, slip counter cleared.
  - Else if timer == SEARCH_CYCLES-1: go to SLIP.
  - If match and timeout occur in the same cycle, match wins.
- SLIP: bitslip_o = 1 for exactly this one cycle. slip_count_o increments mod 4.
  - Internal 3-bit slip counter increments.
  - When that counter reaches 4: set align_err_o (sticky) and reset the counter to 0. Retries continue.
  - Go to SLIP_WAIT.
- SLIP_WAIT: hold for BITSLIP_WAIT cycles, then go to SEARCH with the timer cleared.
- Period per unsuccessful slip = SEARCH_CYCLES + 1 + BITSLIP_WAIT cycles (21 at defaults).
- VERIFY: evaluated on boundary cycles only.
  - match: count++. When count reaches LOCK_COUNT, go to LOCKED.
  - mismatch: go to SEARCH, count = 0, timer cleared, no bitslip.
  - Non-boundary cycles are ignored.
- LOCKED: locked_o = 1, driven from the registered state. On each boundary cycle:
  - cin_word_o <= sr.
  - cin_valid_o <= 1 on the next cycle, i.e. one cycle after the boundary.
  - Result: one valid every 8 cycles, never back-to-back.
  - The pattern is not checked; any data passes. Exit is via align_en_i or reset only.
- Outside LOCKED:
  - cin_valid_o = 0.
  - cin_word_o holds its last value. It is 0 after reset.
- locked_o falls in the same cycle the state leaves LOCKED (registered, one cycle after align_en_i drops).
- No output has a combinational path from inputs.

Test Plan:
- Bit-aligned stream repeating 32'hA55A6996 at nibble phase 0, align_en_i raised -> no bitslip_o.
  - locked_o rises on the 16th boundary match.
  - Then 0x12345678 words are sent -> cin_valid_o every 8 cycles with cin_word_o=0x12345678; slip_count_o=0.
- Same stream delayed by 3 nibbles -> no bitslip; locks.
  - First valid word after lock equals the first data word exactly, with no nibble rotation.
- Bench ISERDES model with 2 bit offset (model rotates 1 bit per pulse) -> exactly 2 bitslip_o pulses, 21 cycles apart, then lock.
  - slip_count_o=2; align_err_o=0.
- Constant cin_i=0 -> bitslip_o pulses every 21 cycles.
  - align_err_o rises the cycle after the 4th pulse and stays high.
  - align_en_i low -> align_err_o=0 and IDLE next cycle.
- Corrupt one training word at VERIFY count 5 -> return to SEARCH with no bitslip.
  - Re-lock only after 16 fresh consecutive matches.
- Assert rst_n_i mid-LOCKED -> all outputs 0 immediately, asynchronously.
  - After release with align_en_i high, the training sequence restarts from SEARCH and relocks.
